cr_axis_frame_mon: RTL and testbench
====================================

// Module: cr_axis_frame_mon
// PURPOSE
//  Synthesizable N-channel AXI-stream frame monitor, tapped passively onto KME/CCEIP/CDDIP stream ports.
//  Per channel it checks:
//  - SoT/EoT framing carried in tuser[1:0];
//  - payload stability while stalled;
//  - tlast consistency;
//  - stall watchdog.
//  It keeps saturating beat/frame statistics and raises sticky per-channel errors plus a summary interrupt.
// PARAMETERS
//  N_CH        4   number of monitored stream channels
//  DWIDTH      64  tdata width per channel
//  UWIDTH      8   tuser width per channel; only tuser[1:0] is decoded
//  SWIDTH      8   tstrb width per channel
//  CNT_WIDTH   32  beat/frame counter width (saturating)
//  WDOG_WIDTH  16  watchdog counter/limit width
// PORTS
//  clk           in   1              clock
//  rst           in   1              synchronous, active-high reset
//  mon_tvalid    in   N_CH           tapped tvalid, one bit per channel
//  mon_tready    in   N_CH           tapped tready
//  mon_tlast     in   N_CH           tapped tlast
//  mon_tuser     in   N_CH*UWIDTH    tapped tuser; ch i at [i*UWIDTH +: UWIDTH]
//  mon_tstrb     in   N_CH*SWIDTH    tapped tstrb
//  mon_tdata     in   N_CH*DWIDTH    tapped tdata
//  tlast_chk_en  in   N_CH           1 = require tlast==(tuser is EoT) on every beat
//  wdog_limit    in   WDOG_WIDTH     stall limit in cycles; 0 disables the watchdog
//  err_clr       in   N_CH           write-1 pulse clears that channel's err_flags
//  stat_clr      in   1              pulse zeroes all counters
//  stat_sel      in   $clog2(N_CH)   channel selected for the stat outputs
//  stat_beats    out  CNT_WIDTH      beat count of the selected channel, registered
//  stat_frames   out  CNT_WIDTH      completed-frame count of the selected channel, registered
//  in_frame      out  N_CH           channel is between SoT and EoT
//  err_flags     out  N_CH*4         sticky per channel: {WDOG,TLAST,STABLE,FRAMING}
//  mon_irq       out  1              registered OR of all err_flags
// BEHAVIOUR
//  Reset: all outputs, counters, flags and FSMs go to 0/IDLE. Reset mid-frame abandons the frame; no error is raised.
//  Beat: tvalid & tready. Decode of tuser[1:0]: 01=SoT, 10=EoT, 11 or 00=MID.
//  Per-channel FSM {IDLE, FRAME}; transitions occur only on beats:
//  - IDLE: SoT -> FRAME. EoT or MID -> FRAMING error, stay IDLE.
//  - FRAME: EoT -> IDLE, frames+1. MID -> stay. SoT -> FRAMING error, stay FRAME (treated as restart; no frame counted).
//  in_frame is 1 exactly when FSM==FRAME, updated the cycle after the beat.
//  Stability: a cycle with tvalid & !tready captures {tdata,tstrb,tuser,tlast} and arms the check.
//  - Next cycle: tvalid==0, or any captured field differs -> STABLE error.
//  - The check disarms on the beat.
//  TLAST: if tlast_chk_en[i] and tlast != (tuser==EoT) on a beat -> TLAST error.
//  Watchdog: while FRAME and no beat this cycle, count +1; a beat or IDLE clears the count.
//  - count == wdog_limit-1 with no beat -> WDOG error (one cycle of latency).
//  - The count holds at the limit; it does not retrigger until a beat occurs.
//  Counters: beats+1 on every beat, independent of errors. Both counters saturate at all-ones.
//  - stat_clr wins over a same-cycle increment.
//  Errors: set the cycle after the detecting beat or cycle.
//  - err_clr and a new set in the same cycle: set wins.
//  - Several errors on one beat set all of the corresponding bits.
//  - mon_irq follows err_flags by one cycle.
//  Stat outputs: registered mux of stat_sel; one-cycle latency. Out-of-range stat_sel reads 0.
//  The block has no backpressure path: it never drives the monitored bus.
// STRUCTURE
//  Package cr_axis_mon_pkg:
//  - tuser codes TUSER_SOT=2'b01, TUSER_EOT=2'b10, TUSER_MID=2'b11;
//  - typedef enum {MON_IDLE, MON_FRAME};
//  - error-bit index constants ERR_FRAMING=0, ERR_STABLE=1, ERR_TLAST=2, ERR_WDOG=3.
//  Sub-module cr_axis_ch_mon: one channel (FSM, stability capture, watchdog, counters).
//  - Instantiated N_CH times by generate.
//  - The top holds only the stat mux and the irq OR.
// TESTING
//  T1  ch0 SoT(tdata 0x15), 3x MID, EoT, tready=1
//      -> stat_frames=1, stat_beats=5, in_frame 1 then 0, err_flags=0.
//  T2  ch1 MID with no prior SoT; then SoT, SoT
//      -> ch1 FRAMING set after the first beat; in_frame[1]=1; stat_frames=0.
//  T3  ch2 tvalid=1, tready=0 for 3 cycles, tdata changes 0xAA->0xAB in cycle 2
//      -> STABLE set next cycle; err_clr[2] pulse clears it; mon_irq drops one cycle later.
//  T4  wdog_limit=16, ch3 in FRAME, tvalid=0 for 20 cycles
//      -> WDOG set 16 cycles after the last beat.
//      wdog_limit=0 repeat -> no WDOG.
//  T5  tlast_chk_en=4'b0001: EoT beat with tlast=0 on ch0 and on ch1
//      -> TLAST only on ch0.
//  T6  CNT_WIDTH=4 build, 20 beats -> stat_beats=15 (saturated).
//      stat_clr same cycle as a beat -> 0.
//      rst mid-frame -> in_frame=0, no error.

Source files
------------

// File: rtl/cr_axis_mon_pkg.sv
// Shared definitions for the AXI-stream frame monitor: tuser framing codes,
// per-channel FSM states and error-bit positions.
package cr_axis_mon_pkg;

  localparam logic [1:0] TUSER_SOT = 2'b01;
  localparam logic [1:0] TUSER_EOT = 2'b10;
  localparam logic [1:0] TUSER_MID = 2'b11;

  typedef enum logic {
    MON_IDLE  = 1'b0,
    MON_FRAME = 1'b1
  } mon_state_e;

  typedef enum logic [1:0] {
    KIND_MID = 2'd0,
    KIND_SOT = 2'd1,
    KIND_EOT = 2'd2
  } beat_kind_e;

  localparam int unsigned ERR_FRAMING = 0;
  localparam int unsigned ERR_STABLE  = 1;
  localparam int unsigned ERR_TLAST   = 2;
  localparam int unsigned ERR_WDOG    = 3;
  localparam int unsigned ERR_W       = 4;

  // 2'b00 carries no framing marker and is handled like a continuation beat.
  function automatic beat_kind_e decode_tuser(input logic [1:0] code);
    beat_kind_e kind;
    unique case (code)
      TUSER_SOT:        kind = KIND_SOT;
      TUSER_EOT:        kind = KIND_EOT;
      TUSER_MID, 2'b00: kind = KIND_MID;
      default:          kind = KIND_MID;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/cr_axis_ch_mon.sv
// Single-channel passive AXI-stream monitor: framing FSM, stall stability check,
// tlast consistency, stall watchdog, saturating beat/frame counters, sticky errors.
module cr_axis_ch_mon
  import cr_axis_mon_pkg::*;
#(
  parameter int unsigned DWIDTH     = 64,
  parameter int unsigned UWIDTH     = 8,
  parameter int unsigned SWIDTH     = 8,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned WDOG_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tvalid_i,
  input  logic                  tready_i,
  input  logic                  tlast_i,
  input  logic [UWIDTH-1:0]     tuser_i,
  input  logic [SWIDTH-1:0]     tstrb_i,
  input  logic [DWIDTH-1:0]     tdata_i,
  input  logic                  tlast_chk_en_i,
  input  logic [WDOG_WIDTH-1:0] wdog_limit_i,
  input  logic                  err_clr_i,
  input  logic                  stat_clr_i,
  output logic [CNT_WIDTH-1:0]  beats_o,
  output logic [CNT_WIDTH-1:0]  frames_o,
  output logic                  in_frame_o,
  output logic [ERR_W-1:0]      err_flags_o
);

  localparam int unsigned CAP_W = DWIDTH + SWIDTH + UWIDTH + 1;

  mon_state_e            state_q;
  logic                  armed_q;
  logic [CAP_W-1:0]      cap_q;
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
  logic [CNT_WIDTH-1:0]  beats_q, frames_q;
  logic [ERR_W-1:0]      err_q, err_set;

  logic                  beat;
  logic                  stall;
  logic [CAP_W-1:0]      fields;
  beat_kind_e            kind;

  always_comb begin
    beat    = tvalid_i & tready_i;
    stall   = tvalid_i & ~tready_i;
    fields  = {tdata_i, tstrb_i, tuser_i, tlast_i};
    kind    = decode_tuser(tuser_i[1:0]);
    err_set = '0;
    wdog_d  = '0;

    if (beat) begin
      unique case (state_q)
        MON_IDLE:  if (kind != KIND_SOT) err_set[ERR_FRAMING] = 1'b1;
        MON_FRAME: if (kind == KIND_SOT) err_set[ERR_FRAMING] = 1'b1;
        default:   err_set[ERR_FRAMING] = 1'b0;
      endcase
      if (tlast_chk_en_i && (tlast_i != (kind == KIND_EOT))) err_set[ERR_TLAST] = 1'b1;
    end

    if (armed_q && (!tvalid_i || (fields != cap_q))) err_set[ERR_STABLE] = 1'b1;

    // Count parks at the limit so a long stall reports exactly once.
    if ((state_q == MON_FRAME) && !beat && (wdog_limit_i != '0)) begin
      wdog_d = (wdog_q < wdog_limit_i) ? wdog_q + 1'b1 : wdog_q;
      if (wdog_q == wdog_limit_i - 1'b1) err_set[ERR_WDOG] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= MON_IDLE;
      armed_q  <= 1'b0;
      cap_q    <= '0;
      wdog_q   <= '0;
      beats_q  <= '0;
      frames_q <= '0;
      err_q    <= '0;
    end else begin
      armed_q <= stall;
      if (stall) cap_q <= fields;
      wdog_q <= wdog_d;
      err_q  <= (err_q & ~{ERR_W{err_clr_i}}) | err_set;

      if (beat) begin
        unique case (state_q)
          MON_IDLE:  if (kind == KIND_SOT) state_q <= MON_FRAME;
          MON_FRAME: if (kind == KIND_EOT) state_q <= MON_IDLE;
          default:   state_q <= MON_IDLE;
        endcase
      end

      if (stat_clr_i) begin
        beats_q  <= '0;
        frames_q <= '0;
      end else begin
        if (beat && (beats_q != '1)) beats_q <= beats_q + 1'b1;
        if (beat && (state_q == MON_FRAME) && (kind == KIND_EOT) && (frames_q != '1))
          frames_q <= frames_q + 1'b1;
      end
    end
  end

  assign beats_o     = beats_q;
  assign frames_o    = frames_q;
  assign in_frame_o  = (state_q == MON_FRAME);
  assign err_flags_o = err_q;

endmodule

// File: rtl/cr_axis_frame_mon.sv
// N-channel passive AXI-stream frame monitor: per-channel monitors plus the
// registered statistics read mux and the summary interrupt.
module cr_axis_frame_mon
  import cr_axis_mon_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DWIDTH     = 64,
  parameter int unsigned UWIDTH     = 8,
  parameter int unsigned SWIDTH     = 8,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned WDOG_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           mon_tvalid,
  input  logic [N_CH-1:0]           mon_tready,
  input  logic [N_CH-1:0]           mon_tlast,
  input  logic [N_CH*UWIDTH-1:0]    mon_tuser,
  input  logic [N_CH*SWIDTH-1:0]    mon_tstrb,
  input  logic [N_CH*DWIDTH-1:0]    mon_tdata,
  input  logic [N_CH-1:0]           tlast_chk_en,
  input  logic [WDOG_WIDTH-1:0]     wdog_limit,
  input  logic [N_CH-1:0]           err_clr,
  input  logic                      stat_clr,
  input  logic [$clog2(N_CH)-1:0]   stat_sel,
  output logic [CNT_WIDTH-1:0]      stat_beats,
  output logic [CNT_WIDTH-1:0]      stat_frames,
  output logic [N_CH-1:0]           in_frame,
  output logic [N_CH*ERR_W-1:0]     err_flags,
  output logic                      mon_irq
);

  logic [CNT_WIDTH-1:0] beats_w  [N_CH];
  logic [CNT_WIDTH-1:0] frames_w [N_CH];
  logic [CNT_WIDTH-1:0] sel_beats_d, sel_frames_d;
  logic [CNT_WIDTH-1:0] stat_beats_q, stat_frames_q;
  logic                 mon_irq_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    cr_axis_ch_mon #(
      .DWIDTH     (DWIDTH),
      .UWIDTH     (UWIDTH),
      .SWIDTH     (SWIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .WDOG_WIDTH (WDOG_WIDTH)
    ) u_ch (
      .clk_i          (clk),
      .rst_i          (rst),
      .tvalid_i       (mon_tvalid[g]),
      .tready_i       (mon_tready[g]),
      .tlast_i        (mon_tlast[g]),
      .tuser_i        (mon_tuser[g*UWIDTH +: UWIDTH]),
      .tstrb_i        (mon_tstrb[g*SWIDTH +: SWIDTH]),
      .tdata_i        (mon_tdata[g*DWIDTH +: DWIDTH]),
      .tlast_chk_en_i (tlast_chk_en[g]),
      .wdog_limit_i   (wdog_limit),
      .err_clr_i      (err_clr[g]),
      .stat_clr_i     (stat_clr),
      .beats_o        (beats_w[g]),
      .frames_o       (frames_w[g]),
      .in_frame_o     (in_frame[g]),
      .err_flags_o    (err_flags[g*ERR_W +: ERR_W])
    );
  end

  // Non-power-of-two channel counts leave select codes with no channel behind them.
  always_comb begin
    sel_beats_d  = '0;
    sel_frames_d = '0;
    if (32'(stat_sel) < N_CH) begin
      sel_beats_d  = beats_w[stat_sel];
      sel_frames_d = frames_w[stat_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats_q  <= '0;
      stat_frames_q <= '0;
      mon_irq_q     <= 1'b0;
    end else begin
      stat_beats_q  <= sel_beats_d;
      stat_frames_q <= sel_frames_d;
      mon_irq_q     <= |err_flags;
    end
  end

  assign stat_beats  = stat_beats_q;
  assign stat_frames = stat_frames_q;
  assign mon_irq     = mon_irq_q;

endmodule

// File: tb/tb_cr_axis_frame_mon.sv
// Self-checking bench for cr_axis_frame_mon: directed scenarios plus a random
// phase, all checked against a cycle-level behavioural model.
module tb_cr_axis_frame_mon;

  localparam int N = 4, DW = 64, UW = 8, SW = 8, CW = 32, WW = 16;
  localparam logic [1:0] C_SOT = 2'b01, C_EOT = 2'b10, C_MID = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      mon_tvalid, mon_tready, mon_tlast, tlast_chk_en, err_clr;
  logic [N*UW-1:0]   mon_tuser;
  logic [N*SW-1:0]   mon_tstrb;
  logic [N*DW-1:0]   mon_tdata;
  logic [WW-1:0]     wdog_limit;
  logic              stat_clr;
  logic [1:0]        stat_sel;
  logic [CW-1:0]     stat_beats, stat_frames;
  logic [N-1:0]      in_frame;
  logic [N*4-1:0]    err_flags;
  logic              mon_irq;

  cr_axis_frame_mon #(.N_CH(N), .DWIDTH(DW), .UWIDTH(UW), .SWIDTH(SW),
                      .CNT_WIDTH(CW), .WDOG_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tlast(mon_tlast), .mon_tuser(mon_tuser), .mon_tstrb(mon_tstrb),
    .mon_tdata(mon_tdata), .tlast_chk_en(tlast_chk_en), .wdog_limit(wdog_limit),
    .err_clr(err_clr), .stat_clr(stat_clr), .stat_sel(stat_sel),
    .stat_beats(stat_beats), .stat_frames(stat_frames), .in_frame(in_frame),
    .err_flags(err_flags), .mon_irq(mon_irq));

  // Narrow-counter instance for the saturation case.
  logic          s_rst, s_stat_clr, s_stat_sel;
  logic [1:0]    s_tvalid, s_tready, s_tlast, s_chk, s_clr, s_in_frame;
  logic [2*UW-1:0] s_tuser;
  logic [2*SW-1:0] s_tstrb;
  logic [2*DW-1:0] s_tdata;
  logic [WW-1:0] s_wdog;
  logic [3:0]    s_stat_beats, s_stat_frames;
  logic [7:0]    s_err_flags;
  logic          s_irq;

  cr_axis_frame_mon #(.N_CH(2), .DWIDTH(DW), .UWIDTH(UW), .SWIDTH(SW),
                      .CNT_WIDTH(4), .WDOG_WIDTH(WW)) dut_s (
    .clk(clk), .rst(s_rst), .mon_tvalid(s_tvalid), .mon_tready(s_tready),
    .mon_tlast(s_tlast), .mon_tuser(s_tuser), .mon_tstrb(s_tstrb),
    .mon_tdata(s_tdata), .tlast_chk_en(s_chk), .wdog_limit(s_wdog),
    .err_clr(s_clr), .stat_clr(s_stat_clr), .stat_sel(s_stat_sel),
    .stat_beats(s_stat_beats), .stat_frames(s_stat_frames), .in_frame(s_in_frame),
    .err_flags(s_err_flags), .mon_irq(s_irq));

  int passed = 0, total = 0, failed = 0;

  // Behavioural model state
  bit          m_frame [N];
  logic [63:0] m_beats [N], m_frames [N];
  logic [3:0]  m_err   [N];
  bit          m_stall [N];
  logic [DW+SW+UW:0] m_cap [N];
  int          m_idle  [N];
  logic [CW-1:0] e_beats, e_frames;
  logic        e_irq;
  localparam logic [63:0] MAXC = (64'd1 << CW) - 64'd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_frame[c] = 0; m_beats[c] = 0; m_frames[c] = 0; m_err[c] = 0;
      m_stall[c] = 0; m_cap[c] = 0; m_idle[c] = 0;
    end
    e_beats = 0; e_frames = 0; e_irq = 0;
  endtask

  task automatic model_cycle();
    logic [3:0] set;
    logic [1:0] code;
    logic [DW+SW+UW:0] f;
    bit v, r, b;
    e_beats  = m_beats[stat_sel][CW-1:0];
    e_frames = m_frames[stat_sel][CW-1:0];
    e_irq = 0;
    for (int c = 0; c < N; c++) e_irq |= |m_err[c];
    for (int c = 0; c < N; c++) begin
      v = mon_tvalid[c]; r = mon_tready[c]; b = v && r;
      code = mon_tuser[c*UW +: 2];
      f = {mon_tdata[c*DW +: DW], mon_tstrb[c*SW +: SW], mon_tuser[c*UW +: UW], mon_tlast[c]};
      set = 0;
      if (m_stall[c] && (!v || f !== m_cap[c])) set[1] = 1;
      m_stall[c] = v && !r;
      m_cap[c] = f;
      if (m_frame[c] && !b && wdog_limit != 0) begin
        m_idle[c]++;
        if (m_idle[c] == int'(wdog_limit)) set[3] = 1;
      end else m_idle[c] = 0;
      if (b) begin
        if (tlast_chk_en[c] && (mon_tlast[c] != (code == C_EOT))) set[2] = 1;
        if (m_beats[c] < MAXC) m_beats[c]++;
        if (!m_frame[c]) begin
          if (code == C_SOT) m_frame[c] = 1; else set[0] = 1;
        end else if (code == C_EOT) begin
          m_frame[c] = 0;
          if (m_frames[c] < MAXC) m_frames[c]++;
        end else if (code == C_SOT) set[0] = 1;
      end
      m_err[c] = (m_err[c] & {4{~err_clr[c]}}) | set;
      if (stat_clr) begin m_beats[c] = 0; m_frames[c] = 0; end
    end
  endtask

  task automatic step();
    logic [N-1:0]   x_if;
    logic [N*4-1:0] x_err;
    model_cycle();
    @(posedge clk); #1;
    for (int c = 0; c < N; c++) begin x_if[c] = m_frame[c]; x_err[c*4 +: 4] = m_err[c]; end
    chk("in_frame", in_frame, x_if);
    chk("err_flags", err_flags, x_err);
    chk("mon_irq", mon_irq, e_irq);
    chk("stat_beats", stat_beats, e_beats);
    chk("stat_frames", stat_frames, e_frames);
  endtask

  task automatic idle_all();
    mon_tvalid = '0; mon_tready = '0; mon_tlast = '0; err_clr = '0; stat_clr = 1'b0;
  endtask

  task automatic set_ch(input int c, input bit v, input bit r, input logic [1:0] code,
                        input bit last, input logic [63:0] d);
    mon_tvalid[c] = v; mon_tready[c] = r; mon_tlast[c] = last;
    mon_tuser[c*UW +: UW] = {6'b0, code};
    mon_tstrb[c*SW +: SW] = '1;
    mon_tdata[c*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_all();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_in_frame", in_frame, '0);
    chk("rst_err_flags", err_flags, '0);
    chk("rst_irq", mon_irq, 1'b0);
    chk("rst_beats", stat_beats, '0);
    chk("rst_frames", stat_frames, '0);
  endtask

  initial begin
    rst = 1'b1; idle_all();
    mon_tuser = '0; mon_tstrb = '0; mon_tdata = '0;
    tlast_chk_en = '0; wdog_limit = '0; stat_sel = '0;
    s_rst = 1'b1; s_stat_clr = 0; s_stat_sel = 0; s_tvalid = '0; s_tready = '0;
    s_tlast = '0; s_chk = '0; s_clr = '0; s_tuser = '0; s_tstrb = '0; s_tdata = '0; s_wdog = '0;
    model_reset();

    // T6a: narrow counters saturate, stat_clr beats a same-cycle increment
    @(posedge clk); #1;
    s_rst = 1'b0; s_tvalid = 2'b01; s_tready = 2'b01;
    repeat (20) begin @(posedge clk); #1; end
    s_tvalid = '0;
    @(posedge clk); #1;
    chk("t6_sat_beats", s_stat_beats, 4'd15);
    s_tvalid = 2'b01; s_stat_clr = 1'b1;
    @(posedge clk); #1;
    s_tvalid = '0; s_stat_clr = 1'b0;
    @(posedge clk); #1;
    chk("t6_small_clr", s_stat_beats, 4'd0);

    do_reset();

    // T1: clean five-beat frame on ch0
    set_ch(0, 1, 1, C_SOT, 0, 64'h15); step();
    chk("t1_in_frame_set", in_frame[0], 1'b1);
    for (int i = 0; i < 3; i++) begin set_ch(0, 1, 1, C_MID, 0, 64'(i)); step(); end
    set_ch(0, 1, 1, C_EOT, 1, 64'h99); step();
    chk("t1_in_frame_clr", in_frame[0], 1'b0);
    idle_all(); stat_sel = 2'd0; step();
    chk("t1_frames", stat_frames, 32'd1);
    chk("t1_beats", stat_beats, 32'd5);
    chk("t1_err", err_flags, '0);

    // T2: ch1 MID before SoT, then double SoT
    set_ch(1, 1, 1, C_MID, 0, 64'h1); step();
    chk("t2_framing", err_flags[4], 1'b1);
    set_ch(1, 1, 1, C_SOT, 0, 64'h2); step();
    set_ch(1, 1, 1, C_SOT, 0, 64'h3); step();
    chk("t2_in_frame", in_frame[1], 1'b1);
    idle_all(); stat_sel = 2'd1; step();
    chk("t2_frames", stat_frames, 32'd0);

    // T3: ch2 payload changes while stalled
    err_clr = '1; step(); err_clr = '0; step();
    chk("t3_irq_clear", mon_irq, 1'b0);
    set_ch(2, 1, 0, C_SOT, 0, 64'hAA); step();
    chk("t3_no_err_yet", err_flags[9], 1'b0);
    set_ch(2, 1, 0, C_SOT, 0, 64'hAB); step();
    chk("t3_stable", err_flags[9], 1'b1);
    step();
    set_ch(2, 1, 1, C_SOT, 0, 64'hAB); step();
    idle_all(); err_clr[2] = 1'b1; step();
    err_clr = '0;
    chk("t3_cleared", err_flags[9], 1'b0);
    chk("t3_irq_lag", mon_irq, 1'b1);
    step();
    chk("t3_irq_drop", mon_irq, 1'b0);

    // T4: watchdog on ch3, then disabled
    wdog_limit = 16'd16;
    set_ch(3, 1, 1, C_SOT, 0, 64'h5); step();
    idle_all();
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("t4_wdog_k%0d", k), err_flags[15], (k >= 16) ? 1'b1 : 1'b0);
    end
    err_clr = '1; step(); err_clr = '0;
    wdog_limit = '0;
    set_ch(3, 1, 1, C_MID, 0, 64'h6); step();
    idle_all();
    repeat (20) step();
    chk("t4_wdog_off", err_flags[15], 1'b0);

    // T5: tlast check enabled only on ch0
    err_clr = '1; step(); err_clr = '0;
    tlast_chk_en = 4'b0001;
    set_ch(0, 1, 1, C_EOT, 0, 64'h7);
    set_ch(1, 1, 1, C_EOT, 0, 64'h8); step();
    chk("t5_tlast_ch0", err_flags[2], 1'b1);
    chk("t5_tlast_ch1", err_flags[6], 1'b0);
    idle_all(); tlast_chk_en = '0;

    // T6b: stat_clr with a beat, then reset mid-frame
    stat_sel = 2'd0;
    set_ch(0, 1, 1, C_MID, 0, 64'h9); stat_clr = 1'b1; step();
    idle_all(); step();
    chk("t6_clr_wins", stat_beats, 32'd0);
    set_ch(0, 1, 1, C_SOT, 0, 64'hA); step();
    chk("t6_in_frame", in_frame[0], 1'b1);
    do_reset();

    // Random phase
    wdog_limit = 16'd6;
    tlast_chk_en = 4'($urandom);
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) begin
        if (mon_tvalid[c] && !mon_tready[c] && $urandom_range(9) != 0) begin
          mon_tready[c] = ($urandom_range(9) < 6);
        end else begin
          logic [1:0] code;
          code = 2'($urandom_range(3));
          mon_tvalid[c] = ($urandom_range(9) < 7);
          mon_tready[c] = ($urandom_range(9) < 6);
          mon_tuser[c*UW +: UW] = {6'($urandom), code};
          mon_tlast[c] = (code == C_EOT) ^ ($urandom_range(15) == 0);
          mon_tstrb[c*SW +: SW] = 8'($urandom);
          mon_tdata[c*DW +: DW] = {$urandom, $urandom};
        end
      end
      err_clr  = ($urandom_range(15) == 0) ? 4'($urandom) : 4'd0;
      stat_clr = ($urandom_range(49) == 0);
      stat_sel = 2'($urandom_range(3));
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
